ccc_lock_seq: RTL

Parametrised clock-conditioning supervisor that sits directly behind an FCCC instance, clocked by its GL0 global.
- Synchronises and qualifies the CCC `LOCK` output.
- Sequences the fabric reset release after lock is qualified.
- Generates up to four independent, programmable clock-enable channels for slower logic domains.
- On loss of lock, drops fabric reset and enables immediately, records the event, and optionally pulses the PLL reset to force a relock.

---
 rtl/ccc_lock_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ccc_lock_seq.sv
// CCC lock supervisor: lock qualification, fabric reset sequencing, clock enables.
// Optional PLL relock pulse on loss of lock: define CCC_LOCK_SEQ_PLL_RESET_EN.
module ccc_lock_seq #(
    parameter int NUM_CH           = 4,
    parameter int DIV_W            = 8,
    parameter int LOCK_QUAL_CYCLES = 1024,
    parameter int PLL_RST_CYCLES   = 64
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    LOCK,
    input  logic [NUM_CH*DIV_W-1:0] DIV,
    input  logic [NUM_CH-1:0]       CH_EN,
    input  logic                    LOSS_CLR,
    output logic [NUM_CH-1:0]       CE,
    output logic                    FAB_RESET_N,
    output logic                    LOCKED,
    output logic                    LOCK_LOST,
    output logic [7:0]              LOSS_CNT,
    output logic                    PLL_ARST_N
);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] QUALIFY   = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;
    localparam logic [1:0] LOST      = 2'd3;

    localparam int QW = $clog2(LOCK_QUAL_CYCLES);
    localparam logic [QW-1:0] QMAX = QW'(LOCK_QUAL_CYCLES - 1);

    if (NUM_CH < 1 || NUM_CH > 4 || LOCK_QUAL_CYCLES < 2 ||
        PLL_RST_CYCLES < 1 || DIV_W < 1) begin : g_bad_param
        $error("ccc_lock_seq: parameter out of range");
    end

    logic          lock_m;
    logic          lock_s;
    logic [1:0]    state;
    logic [1:0]    state_d;
    logic [QW-1:0] qcnt;
    logic [QW-1:0] qcnt_d;
    logic          run;
    logic          loss_evt;
    logic          lost_done;
    logic          lock_lost_q;
    logic [7:0]    loss_cnt_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= LOCK;
            lock_s <= lock_m;
        end
    end

    assign run      = (state == RUN);
    assign loss_evt = run && !lock_s;

`ifdef CCC_LOCK_SEQ_PLL_RESET_EN
    localparam int PW = $clog2(PLL_RST_CYCLES + 1);
    localparam logic [PW-1:0] PMAX = PW'(PLL_RST_CYCLES - 1);

    logic [PW-1:0] pcnt;
    logic          pll_q;

    // Registered so the CCC reset pin never sees decode glitches.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pcnt  <= '0;
            pll_q <= 1'b1;
        end else if (loss_evt) begin
            pcnt  <= '0;
            pll_q <= 1'b0;
        end else if (state == LOST) begin
            if (lost_done) begin
                pll_q <= 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    assign lost_done  = (pcnt == PMAX);
    assign PLL_ARST_N = pll_q;
`else
    assign lost_done  = 1'b1;
    assign PLL_ARST_N = 1'b1;
`endif

    always_comb begin
        state_d = state;
        qcnt_d  = qcnt;
        case (state)
            WAIT_LOCK: begin
                qcnt_d = '0;
                if (lock_s) begin
                    state_d = QUALIFY;
                end
            end
            QUALIFY: begin
                if (!lock_s) begin
                    qcnt_d  = '0;
                    state_d = WAIT_LOCK;
                end else if (qcnt == QMAX) begin
                    qcnt_d  = '0;
                    state_d = RUN;
                end else begin
                    qcnt_d = qcnt + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = LOST;
                end
            end
            LOST: begin
                if (lost_done) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                qcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= WAIT_LOCK;
            qcnt  <= '0;
        end else begin
            state <= state_d;
            qcnt  <= qcnt_d;
        end
    end

    // A loss in the same cycle as a clear keeps the flag set.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= 8'd0;
        end else if (loss_evt) begin
            lock_lost_q <= 1'b1;
            if (loss_cnt_q != 8'hFF) begin
                loss_cnt_q <= loss_cnt_q + 8'd1;
            end
        end else if (LOSS_CLR) begin
            lock_lost_q <= 1'b0;
        end
    end

    assign FAB_RESET_N = run;
    assign LOCKED      = run;
    assign LOCK_LOST   = lock_lost_q;
    assign LOSS_CNT    = loss_cnt_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] div_i;
        logic [DIV_W-1:0] cnt;
        logic             ce_r;

        assign div_i = DIV[i*DIV_W +: DIV_W];

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                cnt  <= '0;
                ce_r <= 1'b0;
            end else if (run && CH_EN[i]) begin
                if (cnt >= div_i) begin
                    cnt  <= '0;
                    ce_r <= 1'b1;
                end else begin
                    cnt  <= cnt + 1'b1;
                    ce_r <= 1'b0;
                end
            end else begin
                cnt  <= '0;
                ce_r <= 1'b0;
            end
        end

        // Gate with the state so enables drop in the first LOST cycle.
        assign CE[i] = ce_r & run;
    end

endmodule
